// File: rtl/ic_skolem_pkg.sv
// Purpose : shared types and helpers for the shift-equality Skolem engine.
// Latency : n/a (types and a pure function only).
// Backpr. : n/a.
// Contents: ic_mode_e (shift direction), ic_state_e (engine FSM states),
//           sat_cnt() which saturates a shift amount to the operand width.
package ic_skolem_pkg;

  typedef enum logic {
    IC_LSHR = 1'b0,
    IC_SHL  = 1'b1
  } ic_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ic_state_e;

  // Widest operand sat_cnt can saturate; callers zero-extend s to this width.
  localparam int unsigned SAT_MAX_W = 64;

  // min(s, width). All bits of s take part in the compare, so a huge shift
  // amount with small low bits still saturates to width.
  function automatic int unsigned sat_cnt(input logic [SAT_MAX_W-1:0] s,
                                          input int unsigned          width);
    if (s >= SAT_MAX_W'(width)) begin
      return width;
    end
    return int'(s[31:0]);
  endfunction

endpackage

// File: rtl/ic_shift_step.sv
// Purpose : one single-bit shift step of the witness register, opposite to the
//           queried shift direction, reporting the bit pushed out.
// Latency : combinational. Backpressure: none (pure function of inputs).
// Ports   : w (current value), mode (query direction) -> w_next, lost_bit.
module ic_shift_step
  import ic_skolem_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] w,
  input  ic_mode_e     mode,
  output logic [W-1:0] w_next,
  output logic         lost_bit
);

  // An LSHR query needs x = t << s, so the witness moves left and any set bit
  // leaving the top breaks the condition; SHL is the mirror image.
  always_comb begin
    w_next   = w;
    lost_bit = 1'b0;
    if (mode == IC_LSHR) begin
      w_next   = w << 1;
      lost_bit = w[W-1];
    end else begin
      w_next   = w >> 1;
      lost_bit = w[0];
    end
  end

endmodule

// File: rtl/ic_eq_shift_skolem_seq.sv
// Purpose : iterative Skolem-witness engine deciding whether x >> s == t
//           (mode 0) or x << s == t (mode 1) is solvable, emitting witness x.
// Latency : min(s,W)+1 cycles from accept to out_valid; one request in flight.
// Backpr. : result held in DONE until out_ready; in_ready low until released.
// Ports   : clk, rst (async, active high); in_valid/in_ready + mode, s, t on
//           the request side; out_valid/out_ready + ic, x on the result side.
// Note    : W must lie in 2..64 (saturation compare is done at 64 bits).
module ic_eq_shift_skolem_seq
  import ic_skolem_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ic,
  output logic [W-1:0] x
);

  ic_state_e      r_state;
  ic_state_e      w_state_nxt;
  ic_mode_e       r_mode;
  logic [W-1:0]   r_w;
  logic           r_lost;
  logic [CW-1:0]  r_cnt;
  logic           r_ic;
  logic [W-1:0]   r_x;

  logic [CW-1:0]  w_cnt_init;
  logic           w_accept;
  logic           w_last_step;
  logic [W-1:0]   w_w_next;
  logic           w_lost_bit;
  logic           w_lost_acc;

  assign w_cnt_init  = CW'(sat_cnt(64'(s), W));
  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_last_step = (r_state == SHIFT) && (r_cnt == CW'(1));
  assign w_lost_acc  = r_lost | w_lost_bit;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign ic        = r_ic;
  assign x         = r_x;

  ic_shift_step #(
    .W (W)
  ) u_step (
    .w        (r_w),
    .mode     (r_mode),
    .w_next   (w_w_next),
    .lost_bit (w_lost_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = (w_cnt_init == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ic/x are written only when a result is produced, so they keep the last
  // result between requests. A zero shift resolves at accept: no bit can be
  // lost and the witness is t itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= IC_LSHR;
      r_w    <= '0;
      r_lost <= 1'b0;
      r_cnt  <= '0;
      r_ic   <= 1'b0;
      r_x    <= '0;
    end else if (w_accept) begin
      r_mode <= ic_mode_e'(mode);
      r_w    <= t;
      r_lost <= 1'b0;
      r_cnt  <= w_cnt_init;
      if (w_cnt_init == '0) begin
        r_ic <= 1'b1;
        r_x  <= t;
      end
    end else if (r_state == SHIFT) begin
      r_w    <= w_w_next;
      r_lost <= w_lost_acc;
      r_cnt  <= r_cnt - CW'(1);
      if (w_last_step) begin
        r_ic <= ~w_lost_acc;
        r_x  <= w_w_next;
      end
    end
  end

endmodule

// File: tb/tb_ic_eq_shift_skolem_seq.sv
module tb_ic_eq_shift_skolem_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid8 = 1'b0;
  logic        out_ready8 = 1'b0;
  logic        in_valid_sw = 1'b0;
  logic        out_ready_sw = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] s = '0;
  logic [15:0] t = '0;

  logic        in_ready8, out_valid8, ic8;
  logic [7:0]  x8;
  logic        in_ready4, out_valid4, ic4;
  logic [3:0]  x4;
  logic        in_ready16, out_valid16, ic16;
  logic [15:0] x16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ic_eq_shift_skolem_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .mode(mode), .s(s[7:0]), .t(t[7:0]), .out_valid(out_valid8),
    .out_ready(out_ready8), .ic(ic8), .x(x8)
  );

  ic_eq_shift_skolem_seq #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_sw), .in_ready(in_ready4),
    .mode(mode), .s(s[3:0]), .t(t[3:0]), .out_valid(out_valid4),
    .out_ready(out_ready_sw), .ic(ic4), .x(x4)
  );

  ic_eq_shift_skolem_seq #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_sw), .in_ready(in_ready16),
    .mode(mode), .s(s), .t(t), .out_valid(out_valid16),
    .out_ready(out_ready_sw), .ic(ic16), .x(x16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference from the closed-form condition, not from the step iteration.
  function automatic void model(input int w, input logic m, input logic [15:0] sv,
                                input logic [15:0] tv, output logic [31:0] eic,
                                output logic [31:0] ex);
    logic [31:0] mask, sm, tm, n, xv;
    mask = (32'd1 << w) - 32'd1;
    sm   = {16'd0, sv} & mask;
    tm   = {16'd0, tv} & mask;
    n    = (sm >= 32'(w)) ? 32'(w) : sm;
    if (!m) begin
      xv  = (tm << n) & mask;
      eic = {31'd0, ((xv >> n) == tm)};
    end else begin
      xv  = tm >> n;
      eic = {31'd0, (((xv << n) & mask) == tm)};
    end
    ex = xv;
  endfunction

  task automatic issue8(input logic m, input logic [15:0] sv, input logic [15:0] tv);
    int guard = 0;
    while (!in_ready8 && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready8) chk("issue_timeout", 32'd0, 32'd1);
    mode = m;
    s = sv;
    t = tv;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
  endtask

  // Called just after the accept edge; latency counts that cycle as 1.
  task automatic wait8(output int lat);
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid8) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic release8;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  task automatic run8(input string tag, input logic m, input logic [15:0] sv,
                      input logic [15:0] tv, input logic e_ic, input logic [7:0] e_x,
                      input int e_lat);
    int lat;
    issue8(m, sv, tv);
    wait8(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_ic"}, {31'd0, ic8}, {31'd0, e_ic});
    chk({tag, "_x"}, {24'd0, x8}, {24'd0, e_x});
    release8();
    chk({tag, "_idle"}, {31'd0, in_ready8}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int lat;
    int vcnt;
    int q[$];
    logic [31:0] e_ic, e_x;

    repeat (2) tick();
    chk("rst_in_ready", {31'd0, in_ready8}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    chk("rst_ic", {31'd0, ic8}, 32'd0);
    chk("rst_x", {24'd0, x8}, 32'd0);
    rst = 1'b0;
    tick();

    run8("lshr_sat",   1'b0, 16'd3,    16'h1F, 1'b1, 8'hF8, 4);
    run8("lshr_unsat", 1'b0, 16'd3,    16'h20, 1'b0, 8'h00, 4);
    run8("shl_sat",    1'b1, 16'd2,    16'h54, 1'b1, 8'h15, 3);
    run8("shl_unsat",  1'b1, 16'd2,    16'h55, 1'b0, 8'h15, 3);
    run8("s0_lshr",    1'b0, 16'd0,    16'hA5, 1'b1, 8'hA5, 1);
    run8("s0_shl",     1'b1, 16'd0,    16'hA5, 1'b1, 8'hA5, 1);
    run8("sbig_t0",    1'b0, 16'h00C8, 16'h00, 1'b1, 8'h00, 9);
    run8("sbig_t1",    1'b0, 16'h00C8, 16'h01, 1'b0, 8'h00, 9);
    run8("sbig_shl",   1'b1, 16'h00C8, 16'h80, 1'b0, 8'h00, 9);

    // Backpressure: result must hold for 5 cycles without out_ready.
    issue8(1'b0, 16'd1, 16'h03);
    wait8(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid8}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready8}, 32'd0);
      chk("bp_ic", {31'd0, ic8}, 32'd1);
      chk("bp_x", {24'd0, x8}, 32'h06);
      tick();
    end
    release8();

    // Inputs churn during SHIFT; result must reflect the accepted values.
    issue8(1'b0, 16'd4, 16'h0F);
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      mode = 1'($urandom);
      s = 16'($urandom);
      t = 16'($urandom);
      tick();
      lat++;
    end
    chk("toggle_lat", 32'(lat), 32'd5);
    chk("toggle_ic", {31'd0, ic8}, 32'd1);
    chk("toggle_x", {24'd0, x8}, 32'hF0);
    release8();

    // Back-to-back with in_valid/out_ready held high: issue interval 4 for s=2.
    mode = 1'b0;
    s = 16'd2;
    t = 16'h0F;
    in_valid8 = 1'b1;
    out_ready8 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (out_valid8) q.push_back(i);
    end
    in_valid8 = 1'b0;
    repeat (6) tick();
    out_ready8 = 1'b0;
    chk("b2b_count", 32'(q.size()), 32'd4);
    if (q.size() >= 3) begin
      chk("b2b_gap0", 32'(q[1] - q[0]), 32'd4);
      chk("b2b_gap1", 32'(q[2] - q[1]), 32'd4);
    end
    chk("b2b_x", {24'd0, x8}, 32'h3C);

    // Reset in the middle of a 6-step request.
    issue8(1'b0, 16'd6, 16'h3C);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready8}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid8}, 32'd0);
    chk("mid_rst_ic", {31'd0, ic8}, 32'd0);
    chk("mid_rst_x", {24'd0, x8}, 32'd0);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid8) vcnt++;
    end
    chk("mid_rst_no_valid", 32'(vcnt), 32'd0);
    run8("post_rst", 1'b0, 16'd6, 16'h03, 1'b1, 8'hC0, 7);

    // Sweep: W=4, 8, 16 run the same request concurrently.
    for (int it = 0; it < 40; it++) begin
      int guard;
      logic        m;
      logic [15:0] sv, tv;
      m  = 1'($urandom);
      sv = 16'($urandom_range(0, 20));
      tv = 16'($urandom);
      if (it % 4 == 0) tv = tv & 16'h0003;
      mode = m;
      s = sv;
      t = tv;
      in_valid8 = 1'b1;
      in_valid_sw = 1'b1;
      tick();
      in_valid8 = 1'b0;
      in_valid_sw = 1'b0;
      guard = 0;
      while (!(out_valid8 && out_valid4 && out_valid16) && guard < 40) begin
        tick();
        guard++;
      end
      if (!(out_valid8 && out_valid4 && out_valid16)) chk("sweep_timeout", 32'd0, 32'd1);
      model(4, m, sv, tv, e_ic, e_x);
      chk("sweep4_ic", {31'd0, ic4}, e_ic);
      chk("sweep4_x", {28'd0, x4}, e_x);
      model(8, m, sv, tv, e_ic, e_x);
      chk("sweep8_ic", {31'd0, ic8}, e_ic);
      chk("sweep8_x", {24'd0, x8}, e_x);
      model(16, m, sv, tv, e_ic, e_x);
      chk("sweep16_ic", {31'd0, ic16}, e_ic);
      chk("sweep16_x", {16'd0, x16}, e_x);
      out_ready8 = 1'b1;
      out_ready_sw = 1'b1;
      tick();
      out_ready8 = 1'b0;
      out_ready_sw = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
